// File: rtl/ibyte_queue.sv
// Instruction-byte queue between fetch and the length decoder: circular byte store,
// up to FETCH_W bytes in per cycle, WIN-byte window out, dec_size bytes retired per cycle.
module ibyte_queue #(
  parameter int FETCH_W = 8,
  parameter int DEPTH   = 32,
  parameter int WIN     = 16,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           fill_valid,
  input  logic [8*FETCH_W-1:0]           fill_bytes,
  input  logic [$clog2(FETCH_W+1)-1:0]   fill_cnt,
  output logic                           fill_ready,
  output logic [8*WIN-1:0]               win_bytes,
  output logic [$clog2(WIN+1)-1:0]       win_valid_cnt,
  output logic [31:0]                    win_eip,
  input  logic [3:0]                     dec_size,
  input  logic                           dec_stall,
  output logic                           inst_avail,
  output logic                           inst_fire,
  input  logic                           flush,
  input  logic [31:0]                    flush_eip,
  output logic [CW-1:0]                  count,
  output logic                           overflow_err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int FCW = $clog2(FETCH_W + 1);
  localparam int WCW = $clog2(WIN + 1);

  logic [7:0]     mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [31:0]    eip;
  logic [FCW-1:0] fill_len;
  logic           fill_acc;
  logic [CW-1:0]  acc_len;
  logic [CW-1:0]  ret_len;

  // Oversized beat counts are clamped to a full beat.
  assign fill_len   = (int'(fill_cnt) > FETCH_W) ? FCW'(FETCH_W) : fill_cnt;
  assign fill_ready = (count <= CW'(DEPTH - FETCH_W));
  assign fill_acc   = fill_valid & fill_ready & ~flush;

  assign win_valid_cnt = (int'(count) >= WIN) ? WCW'(WIN) : WCW'(count);
  assign win_eip       = eip;
  assign inst_avail    = (dec_size != 4'd0) && (int'(dec_size) <= int'(win_valid_cnt)) && !flush;
  assign inst_fire     = inst_avail & ~dec_stall;

  assign acc_len = fill_acc  ? CW'(fill_len) : '0;
  assign ret_len = inst_fire ? CW'(dec_size) : '0;

  // Bytes beyond the valid count are forced to zero so stale storage never leaks out.
  always_comb begin
    win_bytes = '0;
    for (int k = 0; k < WIN; k++) begin
      if (k < int'(win_valid_cnt))
        win_bytes[8*k +: 8] = mem[rd_ptr + PW'(k)];
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_acc) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (k < int'(fill_len))
          mem[wr_ptr + PW'(k)] <= fill_bytes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      eip          <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      eip          <= flush_eip;
      overflow_err <= 1'b0;
    end else begin
      if (fill_acc)
        wr_ptr <= wr_ptr + PW'(fill_len);
      if (fill_valid && !fill_ready)
        overflow_err <= 1'b1;
      if (inst_fire) begin
        rd_ptr <= rd_ptr + PW'(dec_size);
        eip    <= eip + 32'(dec_size);
      end
      count <= count + acc_len - ret_len;
    end
  end

endmodule

// File: doc/ibyte_queue.md
Name: ibyte_queue

Overview:
Parametrised instruction-byte queue for the decode-1 stage. It replaces the fixed 8-byte-in / 13-byte-window buffer. It accepts up to FETCH_W bytes per cycle from fetch into a circular store of DEPTH bytes, and presents a WIN-byte window plus its EIP to the combinational length decoder. It retires dec_size bytes per cycle under a stall handshake, and supports redirect flush with overflow detection.

Parameters:
FETCH_W, 8, bytes delivered per fetch beat
DEPTH, 32, queue capacity in bytes; power of two; DEPTH >= FETCH_W and DEPTH >= WIN
WIN, 16, bytes exposed to the length decoder; covers the max x86 length of 15
CW, $clog2(DEPTH+1), count width (derived)

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fill_valid  in  1  fetch beat valid
fill_bytes  in  8*FETCH_W  byte k at [8k+7:8k]; byte 0 = lowest address
fill_cnt  in  $clog2(FETCH_W+1)  number of valid low bytes in beat
fill_ready  out  1  space for a full FETCH_W beat
win_bytes  out  8*WIN  window; byte 0 = oldest queued byte
win_valid_cnt  out  $clog2(WIN+1)  valid bytes in window, min(count, WIN)
win_eip  out  32  EIP of window byte 0
dec_size  in  4  instruction length from length decoder, 1..15
dec_stall  in  1  decode-2 stall
inst_avail  out  1  whole instruction present in window
inst_fire  out  1  bytes retired this cycle
flush  in  1  redirect; discard all queued bytes
flush_eip  in  32  new EIP on flush
count  out  CW  bytes held
overflow_err  out  1  sticky: beat arrived while !fill_ready

Behaviour:
- State: byte array [DEPTH], rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap), count, eip, overflow_err.
- Reset (reset=0, asynchronous): pointers 0, count 0, eip 0, overflow_err 0. Array contents are don't-care, but no output may depend on them while count=0. Resulting outputs: fill_ready 1, win_valid_cnt 0, win_bytes 0, win_eip 0, inst_avail 0, inst_fire 0.
- fill_ready = (DEPTH - count) >= FETCH_W.
  - Computed from registered count only; a same-cycle retire does not raise it.
- fill_cnt > FETCH_W is treated as FETCH_W.
- fill_valid with fill_cnt=0 is a no-op.
- Fill accept = fill_valid & fill_ready & !flush.
  - Writes fill_cnt bytes at wr_ptr..wr_ptr+fill_cnt-1 mod DEPTH.
  - Advances wr_ptr by fill_cnt.
- fill_valid & !fill_ready & !flush:
  - beat dropped;
  - overflow_err <= 1;
  - count unchanged.
- Window (combinational from registers):
  - win_bytes[k] = array[(rd_ptr+k) mod DEPTH] for k < win_valid_cnt;
  - 8'h00 for k >= win_valid_cnt.
- Fill-to-window latency: 1 cycle. A byte written at edge N is visible after edge N.
- inst_avail = (dec_size != 0) & (dec_size <= win_valid_cnt) & !flush.
- inst_fire = inst_avail & !dec_stall.
- On inst_fire:
  - rd_ptr += dec_size;
  - eip <= eip + dec_size, mod 2^32.
- count_next = count + accepted fill_cnt - (inst_fire ? dec_size : 0).
  - Simultaneous fill and retire are both applied in the same cycle.
- Flush has priority over fill and retire in the same cycle:
  - rd_ptr = wr_ptr = 0;
  - count 0;
  - eip <= flush_eip;
  - overflow_err <= 0;
  - fill beat dropped;
  - inst_fire 0.
- No bubble after flush: a fill in cycle N+1 is visible in cycle N+2.
- dec_size > win_valid_cnt: no retire, wait for more bytes. This covers the page-bound/partial-fetch case.
- dec_size = 0: no retire.
- Wrap: window reads and fill writes crossing index DEPTH-1 -> 0 are contiguous.
- count never exceeds DEPTH. This is guaranteed by the fill_ready rule; assert in the bench.

Test Plan:
(FETCH_W=8, DEPTH=32, WIN=16)
1. Reset release -> count=0, fill_ready=1, win_valid_cnt=0, win_bytes=0, win_eip=0, inst_avail=0.
2. Fill 0x00..0x07 (cnt 8) -> next cycle win_valid_cnt=8, bytes 0..7 = 00..07, bytes 8..15 = 0. Then dec_size=3, dec_stall=0 -> inst_fire=1; next cycle win byte0=0x03, win_eip=3, count=5.
3. At count 5: fill 8 and retire 5 in the same cycle -> count=8, win byte0 = first new byte. Then dec_size=12 with win_valid_cnt=8 -> inst_avail=0, state unchanged. dec_stall=1 with dec_size=2 -> inst_fire=0, count unchanged.
4. Fill to count 25 -> fill_ready=0; a fill_valid beat is dropped, count stays 25, overflow_err=1 and stays 1 until flush.
5. Run 5 fill/retire rounds so rd_ptr crosses 31->0 -> window bytes contiguous across the wrap, e.g. byte0=array[30], byte2=array[0]; count exact throughout.
6. Flush with flush_eip=0x00401000 in the same cycle as a fill and a legal retire -> count=0, win_eip=0x00401000, overflow_err=0, fill dropped. Then drive reset low mid-fill -> all outputs immediately take reset values with no clock edge.
